// File: rtl/bp_me_stream_mem_responder.sv
// Streaming memory responder: one command in flight, backed by a local dword array that is not reset.
// Optional macro BP_ME_STREAM_RESP_LATENCY_EN holds WAIT for latency_p cycles before the response header.
//
// state    | meaning
// IDLE     | ready to accept a command header
// WR_DATA  | consuming write beats into the backing store
// WAIT     | response delay before the header is offered
// RESP_HDR | offering the captured command header as the response
// RD_DATA  | streaming registered read beats
module bp_me_stream_mem_responder #(
    parameter int dword_width_p                = 64,
    parameter int dram_mem_msg_header_width_lp = 64,
    parameter int header_width_p               = dram_mem_msg_header_width_lp,
    parameter int mem_els_p                    = 512,
    parameter int latency_p                    = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [header_width_p-1:0] mem_cmd_header_i,
    input  logic                      mem_cmd_header_v_i,
    output logic                      mem_cmd_header_yumi_o,
    input  logic [dword_width_p-1:0]  mem_cmd_data_i,
    input  logic                      mem_cmd_data_v_i,
    output logic                      mem_cmd_data_yumi_o,
    output logic [header_width_p-1:0] mem_resp_header_o,
    output logic                      mem_resp_header_v_o,
    input  logic                      mem_resp_header_ready_i,
    output logic [dword_width_p-1:0]  mem_resp_data_o,
    output logic                      mem_resp_data_v_o,
    input  logic                      mem_resp_data_ready_i
);

    // Header layout, LSB first: msg_type[3:0] (bit 0 set = write), size[6:4], addr[46:7], payload above.
    localparam int size_lsb_lp = 4;
    localparam int addr_lsb_lp = 7;
    localparam int lg_db_lp    = $clog2(dword_width_p / 8);
    localparam int lg_els_lp   = $clog2(mem_els_p);
    localparam int cnt_w_lp    = $clog2(17);
    localparam int wait_w_lp   = (latency_p > 1) ? $clog2(latency_p) : 1;

`ifdef BP_ME_STREAM_RESP_LATENCY_EN
    localparam logic [wait_w_lp-1:0] wait_load_lp = wait_w_lp'((latency_p > 1) ? latency_p - 1 : 0);
`else
    localparam logic [wait_w_lp-1:0] wait_load_lp = '0;
`endif

    typedef enum logic [2:0] {IDLE, WR_DATA, WAIT, RESP_HDR, RD_DATA} state_e;

    state_e                    state_q, state_d;
    logic [header_width_p-1:0] hdr_q;
    logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
    logic [wait_w_lp-1:0]      wait_q, wait_d;
    logic [dword_width_p-1:0]  rd_data_q;
    logic [dword_width_p-1:0]  mem_q [mem_els_p];

    logic                 hdr_yumi, data_yumi, hdr_v, data_v, we, ld_rd, is_wr;
    logic [2:0]           size_s, lg_beats;
    logic [cnt_w_lp-1:0]  last_cnt;
    logic [lg_els_lp-1:0] mask_idx, base_idx, wr_idx, rd_idx;

    assign is_wr    = hdr_q[0];
    assign size_s   = hdr_q[size_lsb_lp +: 3];
    assign lg_beats = (int'(size_s) > lg_db_lp) ? 3'(int'(size_s) - lg_db_lp) : 3'd0;
    assign last_cnt = cnt_w_lp'((32'd1 << lg_beats) - 32'd1);
    assign mask_idx = lg_els_lp'((32'd1 << lg_beats) - 32'd1);
    assign base_idx = hdr_q[addr_lsb_lp + lg_db_lp +: lg_els_lp] & ~mask_idx;
    assign wr_idx   = base_idx + lg_els_lp'(cnt_q);
    // Read address follows the next-state counter so the beat register is loaded one cycle ahead.
    assign rd_idx   = base_idx + lg_els_lp'(cnt_d);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        hdr_yumi  = 1'b0;
        data_yumi = 1'b0;
        hdr_v     = 1'b0;
        data_v    = 1'b0;
        we        = 1'b0;
        ld_rd     = 1'b0;
        unique case (state_q)
            IDLE: begin
                hdr_yumi = mem_cmd_header_v_i & ~reset_i;
                if (hdr_yumi) begin
                    state_d = mem_cmd_header_i[0] ? WR_DATA : WAIT;
                    cnt_d   = '0;
                    wait_d  = wait_load_lp;
                end
            end
            WR_DATA: begin
                data_yumi = mem_cmd_data_v_i;
                we        = mem_cmd_data_v_i;
                if (mem_cmd_data_v_i) begin
                    if (cnt_q == last_cnt) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_q == '0) state_d = RESP_HDR;
                else              wait_d  = wait_q - 1'b1;
            end
            RESP_HDR: begin
                hdr_v = 1'b1;
                if (mem_resp_header_ready_i) begin
                    if (is_wr) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RD_DATA;
                        cnt_d   = '0;
                        ld_rd   = 1'b1;
                    end
                end
            end
            RD_DATA: begin
                data_v = 1'b1;
                if (mem_resp_data_ready_i) begin
                    if (cnt_q == last_cnt) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        ld_rd = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            if (hdr_yumi) hdr_q     <= mem_cmd_header_i;
            if (ld_rd)    rd_data_q <= mem_q[rd_idx];
        end
    end

    // Backing store survives reset so data written before a reset can still be read back.
    always_ff @(posedge clk_i) begin
        if (we) mem_q[wr_idx] <= mem_cmd_data_i;
    end

    assign mem_cmd_header_yumi_o = hdr_yumi;
    assign mem_cmd_data_yumi_o   = data_yumi;
    assign mem_resp_header_o     = hdr_q;
    assign mem_resp_header_v_o   = hdr_v;
    assign mem_resp_data_o       = rd_data_q;
    assign mem_resp_data_v_o     = data_v;

endmodule

// File: tb/tb_bp_me_stream_mem_responder.sv
// Scoreboard bench for bp_me_stream_mem_responder: expected responses are queued at issue, popped by a monitor.
module tb_bp_me_stream_mem_responder;

    localparam int dw  = 64;
    localparam int hw  = 64;
    localparam int els = 512;
    localparam int lat = 4;
`ifdef BP_ME_STREAM_RESP_LATENCY_EN
    localparam int exp_lat = lat + 1;
`else
    localparam int exp_lat = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [hw-1:0] cmd_hdr;
    logic          cmd_hdr_v;
    logic          cmd_hdr_yumi;
    logic [dw-1:0] cmd_data;
    logic          cmd_data_v;
    logic          cmd_data_yumi;
    logic [hw-1:0] hdr_o;
    logic          hdr_v;
    logic          hdr_rdy = 1'b1;
    logic [dw-1:0] data_o;
    logic          data_v;
    logic          data_rdy = 1'b1;

    always #5 clk = ~clk;

    bp_me_stream_mem_responder #(
        .dword_width_p (dw),
        .header_width_p(hw),
        .mem_els_p     (els),
        .latency_p     (lat)
    ) dut (
        .clk_i                  (clk),
        .reset_i                (rst),
        .mem_cmd_header_i       (cmd_hdr),
        .mem_cmd_header_v_i     (cmd_hdr_v),
        .mem_cmd_header_yumi_o  (cmd_hdr_yumi),
        .mem_cmd_data_i         (cmd_data),
        .mem_cmd_data_v_i       (cmd_data_v),
        .mem_cmd_data_yumi_o    (cmd_data_yumi),
        .mem_resp_header_o      (hdr_o),
        .mem_resp_header_v_o    (hdr_v),
        .mem_resp_header_ready_i(hdr_rdy),
        .mem_resp_data_o        (data_o),
        .mem_resp_data_v_o      (data_v),
        .mem_resp_data_ready_i  (data_rdy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] model_mem [els];
    logic [63:0] exp_hdr_q [$];
    logic [63:0] exp_data_q [$];
    logic [63:0] wdata [16];
    int          ready_mode = 0;
    bit          gaps_en = 0;
    bit          tog = 0;
    int          data_hs = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_beats(input int size);
        int b;
        b = (1 << size) / 8;
        return (b < 1) ? 1 : b;
    endfunction

    function automatic int base_of(input logic [39:0] addr, input int nb);
        int idx;
        idx = int'((addr / 8) % els);
        return (idx / nb) * nb;
    endfunction

    always @(posedge clk) begin
        #1;
        tog = ~tog;
        case (ready_mode)
            0:       begin hdr_rdy = 1'b1; data_rdy = 1'b1; end
            1:       begin hdr_rdy = tog;  data_rdy = tog;  end
            default: begin hdr_rdy = 1'($urandom_range(0, 1)); data_rdy = 1'($urandom_range(0, 1)); end
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", 64'(data_v), 64'd1);
                chk("stall_data_held", data_o, prev_data);
            end
            if (hdr_v && hdr_rdy) begin
                if (exp_hdr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_header: actual %h required none at %0t", hdr_o, $time);
                end else begin
                    chk("resp_header", hdr_o, exp_hdr_q.pop_front());
                end
            end
            if (data_v && data_rdy) begin
                data_hs++;
                if (exp_data_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_data: actual %h required none at %0t", data_o, $time);
                end else begin
                    chk("resp_data", data_o, exp_data_q.pop_front());
                end
            end
            prev_stall = data_v && !data_rdy;
            prev_data  = data_o;
        end
    end

    task automatic do_cmd(input bit wr, input int size, input logic [39:0] addr, input int pre);
        logic [63:0] h;
        logic [3:0]  mt;
        logic [16:0] pl;
        int          nb, base, n, gap;
        bit          got;
        mt   = {3'($urandom_range(0, 7)), wr};
        pl   = 17'($urandom);
        h    = {pl, addr, 3'(size), mt};
        nb   = n_beats(size);
        base = base_of(addr, nb);
        exp_hdr_q.push_back(h);
        for (int k = 0; k < nb; k++) begin
            if (wr) model_mem[(base + k) % els] = wdata[k];
            else    exp_data_q.push_back(model_mem[(base + k) % els]);
        end
        @(posedge clk); #1;
        if (wr && pre > 0) begin
            cmd_data_v = 1'b1;
            cmd_data   = wdata[0];
            for (int i = 0; i < pre; i++) begin
                @(negedge clk);
                chk("early_data_held_off", 64'(cmd_data_yumi), 64'd0);
            end
            @(posedge clk); #1;
        end
        cmd_hdr   = h;
        cmd_hdr_v = 1'b1;
        n = 0; got = 0;
        while (!got && n < 2000) begin
            @(negedge clk);
            n++;
            if (wr && pre > 0) chk("early_data_held_off", 64'(cmd_data_yumi), 64'd0);
            if (cmd_hdr_yumi) got = 1;
        end
        chk("hdr_yumi_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
        cmd_hdr_v = 1'b0;
        if (!got) return;
        if (!wr) begin
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                n++;
                if (hdr_v) break;
            end
            chk("read_latency", 64'(n), 64'(exp_lat));
        end else begin
            for (int k = 0; k < nb; k++) begin
                if (!(k == 0 && pre > 0)) begin
                    gap = gaps_en ? $urandom_range(0, 2) : 0;
                    cmd_data_v = 1'b0;
                    repeat (gap) begin @(posedge clk); #1; end
                    cmd_data_v = 1'b1;
                    cmd_data   = wdata[k];
                end
                n = 0; got = 0;
                while (!got && n < 2000) begin
                    @(negedge clk);
                    n++;
                    if (cmd_data_yumi) got = 1;
                end
                chk("data_yumi_seen", 64'(got), 64'd1);
                @(posedge clk); #1;
            end
            cmd_data_v = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_hdr_q.size() != 0 || exp_data_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 64'(n < 5000), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n;
        rst = 1'b1; cmd_hdr = '0; cmd_hdr_v = 1'b0; cmd_data = '0; cmd_data_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hdr_yumi", 64'(cmd_hdr_yumi), 64'd0);
        chk("reset_data_yumi", 64'(cmd_data_yumi), 64'd0);
        chk("reset_hdr_v", 64'(hdr_v), 64'd0);
        chk("reset_data_v", 64'(data_v), 64'd0);
        chk("reset_hdr_o", hdr_o, 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 16; k++) wdata[k] = 64'(k);
        do_cmd(1, 6, 40'h40, 0);
        do_cmd(0, 6, 40'h40, 0);
        do_cmd(0, 3, 40'h48, 0);
        wait_idle();

        for (int k = 0; k < 16; k++) wdata[k] = {$urandom, $urandom};
        do_cmd(1, 6, 40'h80, 3);
        do_cmd(0, 6, 40'h80, 0);
        wait_idle();

        ready_mode = 1;
        do_cmd(0, 6, 40'h40, 0);
        wait_idle();
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        start = data_hs;
        do_cmd(0, 6, 40'h40, 0);
        n = 0;
        while (data_hs < start + 3 && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        chk("reset_beat_reached", 64'(data_hs >= start + 3), 64'd1);
        rst = 1'b1;
        #1;
        chk("midreset_hdr_v", 64'(hdr_v), 64'd0);
        chk("midreset_data_v", 64'(data_v), 64'd0);
        chk("midreset_hdr_yumi", 64'(cmd_hdr_yumi), 64'd0);
        chk("midreset_data_yumi", 64'(cmd_data_yumi), 64'd0);
        chk("midreset_hdr_o", hdr_o, 64'd0);
        exp_data_q.delete();
        exp_hdr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        do_cmd(0, 6, 40'h40, 0);
        wait_idle();

        for (int i = 0; i < els / 16; i++) begin
            for (int k = 0; k < 16; k++) wdata[k] = {$urandom, $urandom};
            do_cmd(1, 7, 40'(i * 128), 0);
        end
        wait_idle();

        ready_mode = 2;
        gaps_en    = 1;
        repeat (60) begin
            bit wr;
            int size;
            wr   = 1'($urandom_range(0, 1));
            size = $urandom_range(0, 7);
            if (wr) for (int k = 0; k < 16; k++) wdata[k] = {$urandom, $urandom};
            do_cmd(wr, size, 40'($urandom_range(0, 65535)), wr ? $urandom_range(0, 3) : 0);
        end
        wait_idle();

        chk("hdr_queue_empty", 64'(exp_hdr_q.size()), 64'd0);
        chk("data_queue_empty", 64'(exp_data_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_me_stream_mem_responder.md
BP_ME_STREAM_MEM_RESPONDER -- requirements
Module: bp_me_stream_mem_responder

Interface
REQ-001 SHALL have parameter dword_width_p, default 64: width of one data beat.
REQ-002 SHALL have parameter header_width_p, default dram_mem_msg_header_width_lp: width of the command and response headers.
REQ-003 SHALL have parameter mem_els_p, default 512: depth of the backing store in dwords (power of 2).
REQ-004 SHALL have parameter latency_p, default 4: response delay in cycles, used only under the configuration macro.
REQ-005 SHALL have port clk_i  in  1  the single clock; reset is asynchronous and active-high.
REQ-006 SHALL have port reset_i  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port mem_cmd_header_i  in  header_width_p  command header (msg_type, size, addr, payload).
REQ-008 SHALL have port mem_cmd_header_v_i  in  1  command header valid.
REQ-009 SHALL have port mem_cmd_header_yumi_o  out  1  command header consumed.
REQ-010 SHALL have port mem_cmd_data_i  in  dword_width_p  write data beat.
REQ-011 SHALL have port mem_cmd_data_v_i  in  1  write data beat valid.
REQ-012 SHALL have port mem_cmd_data_yumi_o  out  1  write data beat consumed.
REQ-013 SHALL have port mem_resp_header_o  out  header_width_p  response header.
REQ-014 SHALL have port mem_resp_header_v_o  out  1  response header valid.
REQ-015 SHALL have port mem_resp_header_ready_i  in  1  response header sink ready.
REQ-016 SHALL have port mem_resp_data_o  out  dword_width_p  read data beat.
REQ-017 SHALL have port mem_resp_data_v_o  out  1  read data beat valid.
REQ-018 SHALL have port mem_resp_data_ready_i  in  1  read data sink ready.

Function
REQ-019 SHALL implement FSM states IDLE, WR_DATA, WAIT, RESP_HDR, RD_DATA; one command in flight.
REQ-020 SHALL assert mem_cmd_header_yumi_o only in IDLE when mem_cmd_header_v_i is high, and capture the header on that cycle.
REQ-021 SHALL compute beats N = max(1, 2^size / (dword_width_p/8)): size_8 gives 1 beat, size_64 gives 8, size_128 gives 16.
REQ-022 SHALL compute the base dword index as addr[3+:log2(mem_els_p)] with the low log2(N) bits cleared; beat k SHALL access (base+k) mod mem_els_p.
REQ-023 A write header SHALL move IDLE to WR_DATA; a read header SHALL move IDLE to WAIT.
REQ-024 In WR_DATA: mem_cmd_data_yumi_o = mem_cmd_data_v_i; each yumi SHALL write one beat; after beat N-1 the FSM SHALL go to WAIT.
REQ-025 mem_cmd_data_yumi_o SHALL be 0 in every state except WR_DATA; data arriving with or before the header SHALL be held off, not dropped.
REQ-026 WAIT SHALL fall through to RESP_HDR on the next cycle unless the latency feature is enabled.
REQ-027 In RESP_HDR: mem_resp_header_v_o = 1 and mem_resp_header_o = captured command header unchanged.
REQ-028 When the response header handshakes: a read SHALL go to RD_DATA; a write SHALL go to IDLE.
REQ-029 In RD_DATA: mem_resp_data_v_o = 1 with beat k; each handshake SHALL advance k; after beat N-1 handshakes the FSM SHALL go to IDLE.
REQ-030 Read data SHALL be registered so that mem_resp_data_o is stable while valid is high and ready is low.
REQ-031 A new header SHALL be accepted no earlier than the cycle after the return to IDLE, giving a minimum 1-cycle gap.
REQ-032 The beat counter SHALL be log2(17) bits wide; N=1 SHALL complete in one beat.

Reset
REQ-033 reset_i high SHALL asynchronously force IDLE, clear the beat counter, wait counter and captured header, and drive every yumi_o and v_o output to 0.
REQ-034 A reset taken mid-transaction SHALL abandon the transaction with no further beats or header; the backing store is not reset and keeps its contents.

Configuration
REQ-035 Macro BP_ME_STREAM_RESP_LATENCY_EN: when defined, WAIT SHALL hold for latency_p cycles before RESP_HDR; when undefined, WAIT SHALL last exactly 1 cycle and latency_p is ignored.

Verification
REQ-036 Write size_64 at addr 0x40, data 0..7, sink always ready -> 8 data yumis, then one response header equal to the command header; a following read of 0x40 returns beats 0..7 in order.
REQ-037 Read size_8 at addr 0x48 after REQ-036 -> one header, then a single beat of value 1.
REQ-038 Read size_64 with mem_resp_data_ready_i toggling every other cycle -> 8 beats, values held stable while stalled, none duplicated or lost.
REQ-039 Write data valid asserted 3 cycles before its header -> mem_cmd_data_yumi_o stays 0 until WR_DATA is reached, and the written data is correct.
REQ-040 Assert reset_i at beat 3 of an 8-beat read -> all outputs 0 immediately; the next read still returns the stored data.
REQ-041 With BP_ME_STREAM_RESP_LATENCY_EN and latency_p=4, issue a read header -> response header valid exactly 5 cycles after the header yumi; without the macro, 2 cycles after.
